// File: rtl/dma_pkg.sv
// Shared definitions for the chip-bus slot scheduler: owner codes, grant bit
// layout, refresh slot list and default fixed-slot bases.
package dma_pkg;

    // Owner code doubles as the grant bit index; bit 0 stays reserved for IDLE.
    typedef enum logic [3:0] {
        OWN_IDLE = 4'd0,
        OWN_REF  = 4'd1,
        OWN_DSK  = 4'd2,
        OWN_AUD  = 4'd3,
        OWN_SPR  = 4'd4,
        OWN_BPL  = 4'd5,
        OWN_COP  = 4'd6,
        OWN_BLT  = 4'd7,
        OWN_CPU  = 4'd8
    } owner_t;

    localparam int GRANT_W = 9;
    localparam int GB_REF  = 1;
    localparam int GB_DSK  = 2;
    localparam int GB_AUD  = 3;
    localparam int GB_SPR  = 4;
    localparam int GB_BPL  = 5;
    localparam int GB_COP  = 6;
    localparam int GB_BLT  = 7;
    localparam int GB_CPU  = 8;

    localparam logic [7:0] REF_FIRST     = 8'h01;
    localparam logic [6:0] REF_SLOTS     = 7'd4;
    localparam logic [6:0] DSK_SLOTS     = 7'd3;
    localparam logic [6:0] AUD_SLOTS     = 7'd4;
    localparam logic [6:0] SPR_SLOTS     = 7'd16;
    localparam logic [7:0] DEF_DSK_FIRST = 8'h09;
    localparam logic [7:0] DEF_AUD_FIRST = 8'h0F;
    localparam logic [7:0] DEF_SPR_FIRST = 8'h17;

    // off = hpos - base; fixed slots sit on every second CCK from the base.
    function automatic logic slot_hit(input logic [7:0] off, input logic [6:0] count);
        return ~off[0] && (off[7:1] < count);
    endfunction

    function automatic logic [GRANT_W-1:0] owner_to_grant(input owner_t o);
        logic [GRANT_W-1:0] g;
        g = '0;
        if (o != OWN_IDLE) g[o] = 1'b1;
        return g;
    endfunction

endpackage

// File: rtl/dma_fixed_slot_decode.sv
// Combinational decode of the hpos-driven fixed slots (refresh, disk, audio,
// sprite); a fixed slot whose channel is not eligible reports no hit.
module dma_fixed_slot_decode
    import dma_pkg::*;
#(
    parameter logic [7:0] SPR_FIRST = DEF_SPR_FIRST,
    parameter logic [7:0] AUD_FIRST = DEF_AUD_FIRST,
    parameter logic [7:0] DSK_FIRST = DEF_DSK_FIRST
) (
    input  logic [7:0] hpos,
    input  logic       vbl,
    input  logic       vblend,
    input  logic       dmaen,
    input  logic       dskdmaen,
    input  logic       sprdmaen,
    input  logic [3:0] auddmaen,
    input  logic       dsk_req,
    output logic       fixed_hit,
    output owner_t     fixed_owner,
    output logic [2:0] spr_num,
    output logic [1:0] aud_num
);

    logic [7:0] ref_off;
    logic [7:0] dsk_off;
    logic [7:0] aud_off;
    logic [7:0] spr_off;

    assign ref_off = hpos - REF_FIRST;
    assign dsk_off = hpos - DSK_FIRST;
    assign aud_off = hpos - AUD_FIRST;
    assign spr_off = hpos - SPR_FIRST;

    always_comb begin
        fixed_hit   = 1'b0;
        fixed_owner = OWN_IDLE;
        spr_num     = 3'd0;
        aud_num     = 2'd0;
        if (slot_hit(ref_off, REF_SLOTS)) begin
            fixed_hit   = 1'b1;
            fixed_owner = OWN_REF;
        end else if (slot_hit(dsk_off, DSK_SLOTS)) begin
            if (dmaen && dskdmaen && dsk_req) begin
                fixed_hit   = 1'b1;
                fixed_owner = OWN_DSK;
            end
        end else if (slot_hit(aud_off, AUD_SLOTS)) begin
            if (dmaen && auddmaen[aud_off[2:1]]) begin
                fixed_hit   = 1'b1;
                fixed_owner = OWN_AUD;
                aud_num     = aud_off[2:1];
            end
        end else if (slot_hit(spr_off, SPR_SLOTS)) begin
            // Two slots per sprite: the slot index halves to the sprite number.
            if (dmaen && sprdmaen && (!vbl || vblend)) begin
                fixed_hit   = 1'b1;
                fixed_owner = OWN_SPR;
                spr_num     = spr_off[4:2];
            end
        end
    end

endmodule

// File: rtl/dma_slot_scheduler.sv
// Per-CCK chip-bus slot allocator: fixed slots from hpos, free slots shared
// by bitplane/copper/blitter/CPU priority with CPU starvation relief.
module dma_slot_scheduler
    import dma_pkg::*;
#(
    parameter logic [7:0] SPR_FIRST  = DEF_SPR_FIRST,
    parameter logic [7:0] AUD_FIRST  = DEF_AUD_FIRST,
    parameter logic [7:0] DSK_FIRST  = DEF_DSK_FIRST,
    parameter int         STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cck,
    input  logic [7:0]          hpos,
    input  logic                vbl,
    input  logic                vblend,
    input  logic                dmaen,
    input  logic                dskdmaen,
    input  logic                sprdmaen,
    input  logic                bpldmaen,
    input  logic                copen,
    input  logic                blten,
    input  logic [3:0]          auddmaen,
    input  logic                bltpri,
    input  logic                dsk_req,
    input  logic                bpl_req,
    input  logic                cop_req,
    input  logic                blt_req,
    input  logic                cpu_req,
    output logic [3:0]          owner,
    output logic [GRANT_W-1:0]  grant,
    output logic [2:0]          spr_num,
    output logic [1:0]          aud_num
);

    localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

    logic         fix_hit;
    owner_t       fix_owner;
    logic [2:0]   fix_spr;
    logic [1:0]   fix_aud;

    owner_t       owner_p0;
    logic [2:0]   spr_p0;
    logic [1:0]   aud_p0;
    logic [1:0]   starve_p0;
    logic         cpu_block;

    owner_t       owner_p1;
    logic [GRANT_W-1:0] grant_p1;
    logic [2:0]   spr_p1;
    logic [1:0]   aud_p1;
    logic [1:0]   starve_p1;

    dma_fixed_slot_decode #(
        .SPR_FIRST (SPR_FIRST),
        .AUD_FIRST (AUD_FIRST),
        .DSK_FIRST (DSK_FIRST)
    ) u_fixed (
        .hpos        (hpos),
        .vbl         (vbl),
        .vblend      (vblend),
        .dmaen       (dmaen),
        .dskdmaen    (dskdmaen),
        .sprdmaen    (sprdmaen),
        .auddmaen    (auddmaen),
        .dsk_req     (dsk_req),
        .fixed_hit   (fix_hit),
        .fixed_owner (fix_owner),
        .spr_num     (fix_spr),
        .aud_num     (fix_aud)
    );

    // p0: slot decision from the current hpos and requests
    assign cpu_block = !bltpri && cpu_req && (starve_p1 == STARVE_LIM) && !hpos[0];

    always_comb begin
        owner_p0 = OWN_IDLE;
        spr_p0   = 3'd0;
        aud_p0   = 2'd0;
        if (fix_hit) begin
            owner_p0 = fix_owner;
            spr_p0   = fix_spr;
            aud_p0   = fix_aud;
        end else if (dmaen && bpldmaen && bpl_req) begin
            owner_p0 = OWN_BPL;
        end else if (dmaen && copen && cop_req && !hpos[0]) begin
            owner_p0 = OWN_COP;
        end else if (dmaen && blten && blt_req && !cpu_block) begin
            owner_p0 = OWN_BLT;
        end else if (cpu_req && !hpos[0]) begin
            owner_p0 = OWN_CPU;
        end
    end

    always_comb begin
        starve_p0 = starve_p1;
        if (owner_p0 == OWN_CPU || !cpu_req || bltpri) begin
            starve_p0 = 2'd0;
        end else if (owner_p0 == OWN_BLT && starve_p1 != 2'd3) begin
            starve_p0 = starve_p1 + 2'd1;
        end
    end

    // p1: registered slot owner, held for the whole CCK
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_p1  <= OWN_IDLE;
            grant_p1  <= '0;
            spr_p1    <= 3'd0;
            aud_p1    <= 2'd0;
            starve_p1 <= 2'd0;
        end else if (cck) begin
            owner_p1  <= owner_p0;
            grant_p1  <= owner_to_grant(owner_p0);
            spr_p1    <= spr_p0;
            aud_p1    <= aud_p0;
            starve_p1 <= starve_p0;
        end
    end

    assign owner   = owner_p1;
    assign grant   = grant_p1;
    assign spr_num = spr_p1;
    assign aud_num = aud_p1;

endmodule

// File: tb/tb_dma_slot_scheduler.sv
// Directed bench for dma_slot_scheduler: one CCK = one clk with cck=1 then
// one clk with cck=0; outputs are sampled on the falling edge.
module tb_dma_slot_scheduler;

    logic       clk = 1'b0;
    logic       reset, cck;
    logic [7:0] hpos;
    logic       vbl, vblend, dmaen, dskdmaen, sprdmaen, bpldmaen, copen, blten;
    logic [3:0] auddmaen;
    logic       bltpri, dsk_req, bpl_req, cop_req, blt_req, cpu_req;
    logic [3:0] owner;
    logic [8:0] grant;
    logic [2:0] spr_num;
    logic [1:0] aud_num;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    dma_slot_scheduler dut (
        .clk      (clk),
        .reset    (reset),
        .cck      (cck),
        .hpos     (hpos),
        .vbl      (vbl),
        .vblend   (vblend),
        .dmaen    (dmaen),
        .dskdmaen (dskdmaen),
        .sprdmaen (sprdmaen),
        .bpldmaen (bpldmaen),
        .copen    (copen),
        .blten    (blten),
        .auddmaen (auddmaen),
        .bltpri   (bltpri),
        .dsk_req  (dsk_req),
        .bpl_req  (bpl_req),
        .cop_req  (cop_req),
        .blt_req  (blt_req),
        .cpu_req  (cpu_req),
        .owner    (owner),
        .grant    (grant),
        .spr_num  (spr_num),
        .aud_num  (aud_num)
    );

    task automatic slot(input logic [7:0] h);
        @(negedge clk);
        hpos = h;
        cck  = 1'b1;
        @(negedge clk);
        cck  = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (owner !== 4'd0) $display("FAIL reset_owner: got %0d want 0", owner); else passed++;
        checks++; if (grant !== 9'h000) $display("FAIL reset_grant: got %h want 000", grant); else passed++;
        checks++; if (spr_num !== 3'd0) $display("FAIL reset_spr: got %0d want 0", spr_num); else passed++;
        checks++; if (aud_num !== 2'd0) $display("FAIL reset_aud: got %0d want 0", aud_num); else passed++;
        reset = 1'b0;
        slot(8'h01);
        checks++; if (owner !== 4'd1) $display("FAIL ref_owner: got %0d want 1", owner); else passed++;
        checks++; if (grant !== 9'h002) $display("FAIL ref_grant: got %h want 002", grant); else passed++;
    endtask

    task automatic test_hold;
        // request changes during the cck=0 half must not disturb the slot
        hpos    = 8'h40;
        cpu_req = 1'b1;
        @(negedge clk);
        checks++; if (owner !== 4'd1) $display("FAIL hold_owner: got %0d want 1", owner); else passed++;
        cpu_req = 1'b0;
        slot(8'h07);
        checks++; if (owner !== 4'd1) $display("FAIL ref_last: got %0d want 1", owner); else passed++;
        slot(8'h09);
        checks++; if (owner !== 4'd0) $display("FAIL dsk_off_idle: got %0d want 0", owner); else passed++;
    endtask

    task automatic test_audio;
        dmaen    = 1'b1;
        auddmaen = 4'b0100;
        slot(8'h13);
        checks++; if (owner !== 4'd3) $display("FAIL aud_owner: got %0d want 3", owner); else passed++;
        checks++; if (aud_num !== 2'd2) $display("FAIL aud_num: got %0d want 2", aud_num); else passed++;
        checks++; if (grant !== 9'h008) $display("FAIL aud_grant: got %h want 008", grant); else passed++;
        auddmaen = 4'b0000;
        cpu_req  = 1'b1;
        slot(8'h13);
        checks++; if (owner !== 4'd0) $display("FAIL aud_odd_cpu: got %0d want 0", owner); else passed++;
        checks++; if (grant !== 9'h000) $display("FAIL aud_odd_grant: got %h want 000", grant); else passed++;
        cpu_req = 1'b0;
    endtask

    task automatic test_disk;
        dskdmaen = 1'b1;
        dsk_req  = 1'b1;
        slot(8'h0D);
        checks++; if (owner !== 4'd2) $display("FAIL dsk_owner: got %0d want 2", owner); else passed++;
        checks++; if (grant !== 9'h004) $display("FAIL dsk_grant: got %h want 004", grant); else passed++;
        dsk_req = 1'b0;
        slot(8'h0B);
        checks++; if (owner !== 4'd0) $display("FAIL dsk_noreq: got %0d want 0", owner); else passed++;
        dskdmaen = 1'b0;
    endtask

    task automatic test_sprite;
        sprdmaen = 1'b1;
        vbl      = 1'b1;
        vblend   = 1'b0;
        slot(8'h1B);
        checks++; if (owner !== 4'd0) $display("FAIL spr_vbl: got %0d want 0", owner); else passed++;
        vblend = 1'b1;
        slot(8'h1B);
        checks++; if (owner !== 4'd4) $display("FAIL spr_owner: got %0d want 4", owner); else passed++;
        checks++; if (spr_num !== 3'd1) $display("FAIL spr_num1: got %0d want 1", spr_num); else passed++;
        checks++; if (grant !== 9'h010) $display("FAIL spr_grant: got %h want 010", grant); else passed++;
        vbl = 1'b0;
        slot(8'h35);
        checks++; if (spr_num !== 3'd7) $display("FAIL spr_num7: got %0d want 7", spr_num); else passed++;
        slot(8'h37);
        checks++; if (owner !== 4'd0) $display("FAIL spr_past_end: got %0d want 0", owner); else passed++;
        sprdmaen = 1'b0;
        vblend   = 1'b0;
    endtask

    task automatic test_priority;
        bpldmaen = 1'b1; copen = 1'b1; blten = 1'b1;
        bpl_req = 1'b1; cop_req = 1'b1; blt_req = 1'b1; cpu_req = 1'b1;
        slot(8'h40);
        checks++; if (owner !== 4'd5) $display("FAIL pri_bpl: got %0d want 5", owner); else passed++;
        checks++; if (grant !== 9'h020) $display("FAIL pri_bpl_grant: got %h want 020", grant); else passed++;
        bpl_req = 1'b0;
        slot(8'h40);
        checks++; if (owner !== 4'd6) $display("FAIL pri_cop: got %0d want 6", owner); else passed++;
        slot(8'h41);
        checks++; if (owner !== 4'd7) $display("FAIL pri_blt_odd: got %0d want 7", owner); else passed++;
        checks++; if (grant !== 9'h080) $display("FAIL pri_blt_grant: got %h want 080", grant); else passed++;
        cop_req = 1'b0; blt_req = 1'b0; cpu_req = 1'b0;
        slot(8'h50);
        checks++; if (owner !== 4'd0) $display("FAIL pri_idle: got %0d want 0", owner); else passed++;
    endtask

    task automatic test_starve;
        logic [3:0] exp_nasty_off [6];
        exp_nasty_off = '{4'd7, 4'd7, 4'd7, 4'd7, 4'd8, 4'd7};
        bltpri  = 1'b0;
        blt_req = 1'b1;
        cpu_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            slot(8'h40 + 8'(i));
            checks++;
            if (owner !== exp_nasty_off[i]) $display("FAIL starve_%0d: got %0d want %0d", i, owner, exp_nasty_off[i]);
            else passed++;
        end
        bltpri = 1'b1;
        for (int i = 0; i < 6; i++) begin
            slot(8'h40 + 8'(i));
            checks++;
            if (owner !== 4'd7) $display("FAIL nasty_%0d: got %0d want 7", i, owner);
            else passed++;
        end
        bltpri  = 1'b0;
        blt_req = 1'b0;
        cpu_req = 1'b0;
        slot(8'h50);
    endtask

    task automatic test_wrap;
        cpu_req = 1'b1;
        slot(8'hFF);
        checks++; if (owner !== 4'd0) $display("FAIL wrap_ff: got %0d want 0", owner); else passed++;
        slot(8'h00);
        checks++; if (owner !== 4'd8) $display("FAIL wrap_00_cpu: got %0d want 8", owner); else passed++;
        checks++; if (grant !== 9'h100) $display("FAIL wrap_00_grant: got %h want 100", grant); else passed++;
        cpu_req = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [3:0] exp_after [4];
        exp_after = '{4'd7, 4'd7, 4'd7, 4'd8};
        // build up starvation to 2, then hold it through a copper slot
        blt_req = 1'b1;
        cpu_req = 1'b1;
        slot(8'h40);
        slot(8'h41);
        cop_req = 1'b1;
        slot(8'h42);
        checks++; if (owner !== 4'd6) $display("FAIL mid_cop: got %0d want 6", owner); else passed++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (owner !== 4'd0) $display("FAIL mid_reset_owner: got %0d want 0", owner); else passed++;
        checks++; if (grant !== 9'h000) $display("FAIL mid_reset_grant: got %h want 000", grant); else passed++;
        cop_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            slot(8'h40 + 8'(2 * i));
            checks++;
            if (owner !== exp_after[i]) $display("FAIL mid_starve_%0d: got %0d want %0d", i, owner, exp_after[i]);
            else passed++;
        end
        blt_req = 1'b0;
        cpu_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cck = 1'b0; hpos = 8'h00;
        vbl = 1'b0; vblend = 1'b0; dmaen = 1'b0; dskdmaen = 1'b0; sprdmaen = 1'b0;
        bpldmaen = 1'b0; copen = 1'b0; blten = 1'b0; auddmaen = 4'b0000;
        bltpri = 1'b0; dsk_req = 1'b0; bpl_req = 1'b0; cop_req = 1'b0;
        blt_req = 1'b0; cpu_req = 1'b0;
        test_reset;
        test_hold;
        test_audio;
        test_disk;
        test_sprite;
        test_priority;
        test_starve;
        test_wrap;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
